csa_sub_pipe: RTL and testbench
===============================

// Module: csa_sub_pipe
// PURPOSE
//   Pipelined WIDTH-bit subtractor computing a - b - bin. Implemented as a + ~b + ~bin
//   on GROUP-bit carry-skip groups. The groups are split across STAGES registered stages.
//   It is the subtract-side counterpart of the structural carry-skip adder.
//   It sits on the datapath behind a valid/ready handshake and accepts one operation per cycle.
// PARAMETERS
//   WIDTH   32  operand/result width; must be divisible by GROUP*STAGES
//   GROUP   4   bits per carry-skip group (group propagate = AND of the GROUP p bits)
//   STAGES  2   pipeline stages; stage k resolves bits [k*WIDTH/STAGES +: WIDTH/STAGES]
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operands valid
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow in (carry-in to add path when op=1)
//   op         in   1      only with CSA_SUB_ADD_EN: 0=subtract, 1=add
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   diff       out  WIDTH  result, mod 2^WIDTH
//   bout       out  1      subtract: borrow out; add: carry out
//   ovf        out  1      signed (two's complement) overflow
// BEHAVIOUR
//   - Reset (rst=1 at edge): all stage valids=0, out_valid=0, diff=0, bout=0, ovf=0.
//     In-flight operations are discarded, none emerge after reset. in_ready=1 from the first cycle after reset.
//   - Transfer on in: in_valid&&in_ready. Transfer on out: out_valid&&out_ready.
//   - Latency: STAGES cycles from accept edge to out_valid=1. Throughput: 1 op/cycle when out_ready=1.
//   - Stage advance: stage k loads when stage k is empty or stage k+1 loads (last stage: out_ready).
//     in_ready = !v[0] || stage0 advances. in_ready is combinational from out_ready through the valid chain.
//   - Each stage carries its partial diff slice, the carry into the next slice, and the unprocessed
//     upper operand bits. Stage 0 input carry = ~bin (subtract) or bin (add).
//   - Within a slice: p=a^b', g=a&b', ripple per bit. Group carry-out = group_p ? group carry-in : ripple carry.
//   - Final: bout = ~carry_out (subtract) / carry_out (add). ovf = carry into MSB XOR carry out of MSB.
//   - diff/bout/ovf hold stable while out_valid && !out_ready. No drop, no duplication, FIFO order preserved.
//   - Simultaneous accept and emit on a full pipe is legal and sustains 1 op/cycle.
//   - With out_ready=0, the pipe holds STAGES ops, then in_ready=0.
//   - Outputs are don't-care only when out_valid=0. They are registered, never combinational from a/b.
// CONFIGURATION
//   CSA_SUB_ADD_EN defined: op port present. op=1 adds (b' = b, cin = bin); op=0 subtracts.
//     op is captured with the operands and travels with them through the stages.
//   CSA_SUB_ADD_EN undefined: no op port, block always subtracts, b' = ~b.
// TESTING
//   1 a=0x00000005 b=0x00000003 bin=0 -> after 2 cycles diff=0x00000002 bout=0 ovf=0
//   2 a=0x00000000 b=0x00000001 bin=0 -> diff=0xFFFFFFFF bout=1 ovf=0
//     (borrow crosses every skip group and the stage boundary)
//   3 a=0x80000000 b=0x00000001 bin=0 -> diff=0x7FFFFFFF bout=0 ovf=1;
//     a=0x12345678 b=0x12345678 bin=1 -> diff=0xFFFFFFFF bout=1 ovf=0
//   4 Three back-to-back ops, out_ready=0 for 4 cycles -> in_ready=0 after 2 accepted.
//     Results emerge in order with values held stable. The third op is accepted when out_ready rises.
//   5 Two ops in flight, rst=1 for 1 cycle -> out_valid=0 and diff=0 next cycle.
//     No stale result appears; a new op returns after 2 cycles.
//   6 CSA_SUB_ADD_EN, op=1, a=0xFFFFFFFF b=0x00000000 bin=1 -> diff=0x00000000 bout=1 ovf=0;
//     op=0 on the next op -> subtract result correct, no cross-contamination

Source files
------------

// File: rtl/csa_sub_pipe.sv
// Pipelined carry-skip subtractor: diff = a - b - bin, resolved one WIDTH/STAGES slice per stage.
// Optional add mode (op port) is enabled by defining CSA_SUB_ADD_EN.
module csa_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef CSA_SUB_ADD_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int NGRP  = SLICE / GROUP;
    localparam int LAST  = STAGES - 1;
    localparam int OPS   = (STAGES > 1) ? STAGES - 1 : 1;

    logic             op_in;
    logic             cin0;
    logic [WIDTH-1:0] b_eff;

`ifdef CSA_SUB_ADD_EN
    assign op_in = op;
    assign b_eff = op ? b : ~b;
    assign cin0  = op ? bin : ~bin;
`else
    assign op_in = 1'b0;
    assign b_eff = ~b;
    assign cin0  = ~bin;
`endif

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  opa_q  [OPS];
    logic [WIDTH-1:0]  opb_q  [OPS];
    logic [OPS-1:0]    carry_q;
    logic [OPS-1:0]    op_q;
    logic [WIDTH-1:0]  diff_q [STAGES];
    logic              bout_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  opa_d  [OPS];
    logic [WIDTH-1:0]  opb_d  [OPS];
    logic [OPS-1:0]    carry_d;
    logic [OPS-1:0]    op_d;
    logic [WIDTH-1:0]  diff_d [STAGES];
    logic              bout_d;
    logic              ovf_d;

    // Advance chain runs from the output back to the input so a full pipe can
    // accept and emit in the same cycle.
    always_comb begin
        logic nxt;
        load = '0;
        nxt  = !v_q[LAST] || out_ready;
        load[LAST] = nxt;
        for (int k = LAST - 1; k >= 0; k--) begin
            nxt     = !v_q[k] || nxt;
            load[k] = nxt;
        end
    end

    assign in_ready = load[0];

    always_comb begin
        logic [WIDTH-1:0] sa, sb, sd;
        logic             c, o, cm, gcin, gp, p, gen;
        int               idx;
        // NOTE: every comb output gets a default first so no path can infer a latch.
        for (int k = 0; k < OPS; k++) begin
            opa_d[k] = '0;
            opb_d[k] = '0;
        end
        for (int k = 0; k < STAGES; k++) diff_d[k] = '0;
        carry_d = '0;
        op_d    = '0;
        bout_d  = 1'b0;
        ovf_d   = 1'b0;
        sa = '0; sb = '0; sd = '0;
        c = 1'b0; o = 1'b0; cm = 1'b0; gcin = 1'b0; gp = 1'b0; p = 1'b0; gen = 1'b0;
        idx = 0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                sa = a;
                sb = b_eff;
                sd = '0;
                c  = cin0;
                o  = op_in;
            end else begin
                sa = opa_q[(k > 0) ? k - 1 : 0];
                sb = opb_q[(k > 0) ? k - 1 : 0];
                sd = diff_q[(k > 0) ? k - 1 : 0];
                c  = carry_q[(k > 0) ? k - 1 : 0];
                o  = op_q[(k > 0) ? k - 1 : 0];
            end
            cm = c;
            // NOTE: blocking assignments here model the ripple; c is reused bit to bit.
            for (int g = 0; g < NGRP; g++) begin
                gcin = c;
                gp   = 1'b1;
                for (int i = 0; i < GROUP; i++) begin
                    idx = g * GROUP + i;
                    p   = sa[idx] ^ sb[idx];
                    gen = sa[idx] & sb[idx];
                    if (idx == SLICE - 1) cm = c;
                    sd[k*SLICE + idx] = p ^ c;
                    c  = gen | (p & c);
                    gp = gp & p;
                end
                if (gp) c = gcin;
            end
            diff_d[k] = sd;
            if (k < LAST) begin
                // Remaining operand bits shift down so the next slice always sits at the LSBs.
                opa_d[(k < OPS) ? k : 0]   = sa >> SLICE;
                opb_d[(k < OPS) ? k : 0]   = sb >> SLICE;
                carry_d[(k < OPS) ? k : 0] = c;
                op_d[(k < OPS) ? k : 0]    = o;
            end else begin
                bout_d = o ? c : ~c;
                ovf_d  = cm ^ c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, so diff/bout/ovf read 0 after reset.
            v_q     <= '0;
            carry_q <= '0;
            op_q    <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) diff_q[k] <= '0;
            for (int k = 0; k < OPS; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k]    <= (k == 0) ? in_valid : v_q[(k > 0) ? k - 1 : 0];
                    diff_q[k] <= diff_d[k];
                end
            end
            for (int k = 0; k < OPS; k++) begin
                if (load[k]) begin
                    opa_q[k]   <= opa_d[k];
                    opb_q[k]   <= opb_d[k];
                    carry_q[k] <= carry_d[k];
                    op_q[k]    <= op_d[k];
                end
            end
            if (load[LAST]) begin
                bout_q <= bout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign diff      = diff_q[LAST];
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_sub_pipe.sv
// Scoreboard bench for csa_sub_pipe: directed corner cases plus randomized traffic
// with random backpressure, checked against an arithmetic reference model.
module tb_csa_sub_pipe;

    localparam int W = 32;
`ifdef CSA_SUB_ADD_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    always #5 clk = ~clk;

    csa_sub_pipe #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
`ifdef CSA_SUB_ADD_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce to WIDTH bits and flags.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic add);
        longint ux, uy, sx, sy, u, s;
        exp_t   e;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (add) begin
            u = ux + uy + longint'(c);
            s = sx + sy + longint'(c);
        end else begin
            u = ux - uy - longint'(c);
            s = sx - sy - longint'(c);
        end
        e.diff = u[W-1:0];
        e.bout = add ? (u >= (longint'(1) << W)) : (u < 0);
        e.ovf  = (s >= (longint'(1) << (W - 1))) || (s < -(longint'(1) << (W - 1)));
        return e;
    endfunction

    // Stimulus side of the scoreboard: every accepted operation pushes its expectation.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)
            sb_q.push_back(model(a, b, bin, ADD_EN ? op : 1'b0));
    end

    // Monitor: the head result must be presented, and held, until it is taken.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_output: got out_valid=1 diff=%0h required no pending result", diff);
            end else begin
                check("mon_diff", 64'(diff), 64'(sb_q[0].diff));
                check("mon_bout", 64'(bout), 64'(sb_q[0].bout));
                check("mon_ovf",  64'(ovf),  64'(sb_q[0].ovf));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic o, input bit rnd);
        bit acc;
        a        = x;
        b        = y;
        bin      = c;
        op       = ADD_EN ? o : 1'b0;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles required accept");
        end
    endtask

    task automatic idle(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Single op on a ready pipe; the result is at the output one edge after acceptance.
    task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c, input logic o,
                            input logic [W-1:0] ed, input logic eb, input logic eo);
        send(x, y, c, o, 1'b0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, 64'(out_valid), 64'(1));
        check({name, "_diff"},  64'(diff),      64'(ed));
        check({name, "_bout"},  64'(bout),      64'(eb));
        check({name, "_ovf"},   64'(ovf),       64'(eo));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        bit drained;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; op = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_diff",      64'(diff),      64'(0));
        check("rst_bout",      64'(bout),      64'(0));
        check("rst_ovf",       64'(ovf),       64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));

        // Latency: not valid right after the accept edge, valid after the next one.
        send(32'h5, 32'h3, 1'b0, 1'b0, 1'b0);
        check("lat_accept_edge", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("lat_valid", 64'(out_valid), 64'(1));
        check("t1_diff",   64'(diff),      64'(32'h2));
        check("t1_bout",   64'(bout),      64'(0));
        check("t1_ovf",    64'(ovf),       64'(0));

        directed("t2", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        directed("t3a", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        directed("t3b", 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        idle(2, 1'b0);

        // Backpressure: two ops fill the pipe, the third waits for out_ready.
        out_ready = 1'b0;
        send(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0020, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; bin = 1'b1; op = 1'b0; in_valid = 1'b1;
        #1;
        check("t4_full_ready", 64'(in_ready), 64'(0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("t4_hold_ready", 64'(in_ready), 64'(0));
            check("t4_hold_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        #1;
        check("t4_ready_rise", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        idle(4, 1'b0);

        // Reset with two ops in flight: nothing stale may emerge afterwards.
        send(32'h1111_1111, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        send(32'h2222_2222, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        check("t5_out_valid", 64'(out_valid), 64'(0));
        check("t5_diff",      64'(diff),      64'(0));
        check("t5_in_ready",  64'(in_ready),  64'(1));
        idle(2, 1'b0);
        check("t5_no_stale", 64'(out_valid), 64'(0));
        directed("t5_new", 32'd100, 32'd58, 1'b1, 1'b0, 32'h29, 1'b0, 1'b0);
        idle(2, 1'b0);

`ifdef CSA_SUB_ADD_EN
        directed("t6_add", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        directed("t6_sub", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'hFFFF_FFF0, 1'b1, 1'b0);
        idle(2, 1'b0);
`endif

        // Random traffic with random gaps and random backpressure.
        for (int i = 0; i < 400; i++) begin
            send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b1);
        end

        out_ready = 1'b1;
        drained = 1'b0;
        for (int n = 0; n < 50 && !drained; n++) begin
            @(posedge clk);
            #1;
            drained = (sb_q.size() == 0) && !out_valid;
        end
        check("drain_pending", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
